// File: rtl/dp_sequencer_if.sv
// Control bundle between the instruction source/ALU and the dp_sequencer.
// The master side supplies the instruction and ALU flags. The slave side drives the datapath controls.
interface dp_sequencer_if;
  logic        START;
  logic [31:0] IR_IN;
  logic [3:0]  FLAGS_OUT;
  logic [19:0] RSLCT;
  logic [4:0]  OP;
  logic        S;
  logic        ALU_OUT;
  logic [3:0]  FLAGS;
  logic        LOAD;
  logic        LOADPC;
  logic        IR_CU;
  logic        BUSY;
  logic        DONE;
  logic        ILLEGAL;

  modport master (
    output START, IR_IN, FLAGS_OUT,
    input  RSLCT, OP, S, ALU_OUT, FLAGS, LOAD, LOADPC, IR_CU, BUSY, DONE, ILLEGAL
  );

  modport slave (
    input  START, IR_IN, FLAGS_OUT,
    output RSLCT, OP, S, ALU_OUT, FLAGS, LOAD, LOADPC, IR_CU, BUSY, DONE, ILLEGAL
  );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for one ARM register-operand data-processing instruction.
// It holds the NZCV flags and evaluates the condition code for each instruction.
module dp_sequencer #(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic          Clk,
  input  logic          RESET,
  dp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_PCINC,
    ST_DONE
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic        illegal;
  logic        cond_pass;
  logic        is_test;
  logic        n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = bus.FLAGS;

  // Selects and opcode come straight from the latched word. They are zero whenever the controller does not own the bus.
  assign bus.RSLCT = bus.IR_CU ? {4'h0, ir[11:8], ir[3:0], ir[19:16], ir[15:12]} : 20'h0;
  assign bus.OP    = bus.IR_CU ? {1'b0, ir[24:21]} : 5'h0;

  assign illegal = (ir[27:26] != 2'b00) | ir[25] | (ir[11:4] != 8'h00) | (ir[31:28] == 4'hF);
  assign is_test = (ir[24:21] == 4'b1000) | (ir[24:21] == 4'b1001) |
                   (ir[24:21] == 4'b1010) | (ir[24:21] == 4'b1011);

  always_comb begin
    cond_pass = 1'b0;
    case (ir[31:28])
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = !z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = !c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = !n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = !v_f;
      4'h8:    cond_pass = c_f && !z_f;
      4'h9:    cond_pass = !c_f || z_f;
      4'hA:    cond_pass = (n_f == v_f);
      4'hB:    cond_pass = (n_f != v_f);
      4'hC:    cond_pass = !z_f && (n_f == v_f);
      4'hD:    cond_pass = z_f || (n_f != v_f);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // NOTE: every register here uses <=, so all decisions in one edge see the same pre-edge values.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      // NOTE: a reset in the middle of an instruction clears every strobe at once. A partial write or PC load cannot follow.
      state       <= ST_IDLE;
      ir          <= 32'h0;
      bus.FLAGS   <= 4'h0;
      bus.S       <= 1'b0;
      bus.ALU_OUT <= 1'b0;
      bus.LOAD    <= 1'b0;
      bus.LOADPC  <= 1'b0;
      bus.IR_CU   <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
      bus.ILLEGAL <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            ir        <= bus.IR_IN;
            bus.IR_CU <= 1'b1;
            bus.BUSY  <= 1'b1;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            bus.DONE    <= 1'b1;
            bus.ILLEGAL <= 1'b1;
            state       <= ST_DONE;
          end else if (!cond_pass) begin
            bus.LOADPC <= 1'b1;
            state      <= ST_PCINC;
          end else begin
            bus.ALU_OUT <= 1'b1;
            bus.S       <= ir[20];
            bus.LOAD    <= !is_test;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ir[20]) bus.FLAGS <= bus.FLAGS_OUT;
          bus.ALU_OUT <= 1'b0;
          bus.S       <= 1'b0;
          bus.LOAD    <= 1'b0;
          // A write to the PC register replaces the sequential increment.
          bus.LOADPC  <= !(bus.LOAD && (ir[15:12] == PC_REG));
          state       <= ST_PCINC;
        end
        ST_PCINC: begin
          bus.LOADPC <= 1'b0;
          bus.DONE   <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          bus.DONE    <= 1'b0;
          bus.ILLEGAL <= 1'b0;
          bus.BUSY    <= 1'b0;
          bus.IR_CU   <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer. Each issued instruction queues a predicted outcome.
// The outcome is popped and compared when the DUT raises DONE.
module tb_dp_sequencer;

  logic Clk   = 1'b0;
  logic RESET = 1'b0;
  always #5 Clk = ~Clk;

  dp_sequencer_if bus ();

  dp_sequencer #(.PC_REG(4'd15)) dut (
    .Clk  (Clk),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] ir;
    int          latency;
    logic        illegal;
    int          n_load;
    int          n_loadpc;
    int          n_s;
    int          n_alu;
    logic [3:0]  flags;
    logic [19:0] rslct;
    logic [4:0]  op;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_flags;
  int         checks = 0;
  int         errors = 0;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(input logic [31:0] ir, input logic [3:0] fo);
    exp_t e;
    logic exec, tst;
    e.ir       = ir;
    e.illegal  = (ir[27:26] != 2'b00) || ir[25] || (ir[11:4] != 8'h00) || (ir[31:28] == 4'hF);
    exec       = !e.illegal && cond_ok(ir[31:28], model_flags);
    tst        = (ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11);
    e.latency  = e.illegal ? 1 : (exec ? 3 : 2);
    e.n_alu    = exec ? 1 : 0;
    e.n_load   = (exec && !tst) ? 1 : 0;
    e.n_s      = (exec && ir[20]) ? 1 : 0;
    e.n_loadpc = e.illegal ? 0 : ((e.n_load == 1 && ir[15:12] == 4'd15) ? 0 : 1);
    e.flags    = (exec && ir[20]) ? fo : model_flags;
    e.rslct    = {4'h0, ir[11:8], ir[3:0], ir[19:16], ir[15:12]};
    e.op       = {1'b0, ir[24:21]};
    return e;
  endfunction

  // Issue one instruction, watch until DONE, and score it against the queued prediction.
  task automatic run_instr(input logic [31:0] ir, input logic [3:0] fo);
    exp_t e;
    int done_n = -1, n_load = 0, n_loadpc = 0, n_s = 0, n_alu = 0, busy_err = 0;
    logic ill = 1'b0;
    logic [19:0] rslct = '0;
    logic [4:0]  op = '0;
    logic        ircu = 1'b0;
    @(negedge Clk);
    bus.IR_IN     = ir;
    bus.FLAGS_OUT = fo;
    bus.START     = 1'b1;
    sb.push_back(predict(ir, fo));
    model_flags = sb[$].flags;
    @(posedge Clk);
    #1 bus.START = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge Clk);
      if (n == 0) begin rslct = bus.RSLCT; ircu = bus.IR_CU; end
      if (bus.ALU_OUT) op = bus.OP;
      n_load   += int'(bus.LOAD);
      n_loadpc += int'(bus.LOADPC);
      n_s      += int'(bus.S);
      n_alu    += int'(bus.ALU_OUT);
      if (!bus.BUSY) busy_err++;
      if (bus.DONE) begin done_n = n; ill = bus.ILLEGAL; break; end
    end
    e = sb.pop_front();
    checks++;
    if (done_n < 0) begin
      errors++; $display("FAIL timeout ir=%h: no DONE within 12 cycles", e.ir);
    end else begin
      checks += 9;
      if (done_n !== e.latency) begin errors++; $display("FAIL latency ir=%h: got %0d want %0d", e.ir, done_n, e.latency); end
      if (ill !== e.illegal) begin errors++; $display("FAIL illegal ir=%h: got %b want %b", e.ir, ill, e.illegal); end
      if (n_load !== e.n_load) begin errors++; $display("FAIL load_count ir=%h: got %0d want %0d", e.ir, n_load, e.n_load); end
      if (n_loadpc !== e.n_loadpc) begin errors++; $display("FAIL loadpc_count ir=%h: got %0d want %0d", e.ir, n_loadpc, e.n_loadpc); end
      if (n_s !== e.n_s) begin errors++; $display("FAIL s_count ir=%h: got %0d want %0d", e.ir, n_s, e.n_s); end
      if (n_alu !== e.n_alu) begin errors++; $display("FAIL alu_out_count ir=%h: got %0d want %0d", e.ir, n_alu, e.n_alu); end
      if (bus.FLAGS !== e.flags) begin errors++; $display("FAIL flags ir=%h: got %b want %b", e.ir, bus.FLAGS, e.flags); end
      if (rslct !== e.rslct || ircu !== 1'b1) begin
        errors++; $display("FAIL decode_rslct ir=%h: got %h ir_cu=%b want %h ir_cu=1", e.ir, rslct, ircu, e.rslct);
      end
      if (busy_err != 0) begin errors++; $display("FAIL busy ir=%h: BUSY low in %0d cycles", e.ir, busy_err); end
      if (e.n_alu == 1) begin
        checks++;
        if (op !== e.op) begin errors++; $display("FAIL op ir=%h: got %b want %b", e.ir, op, e.op); end
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({bus.RSLCT, bus.OP, bus.S, bus.ALU_OUT, bus.FLAGS, bus.LOAD, bus.LOADPC,
         bus.IR_CU, bus.BUSY, bus.DONE, bus.ILLEGAL} !== 37'h0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, rslct=%h flags=%b busy=%b", bus.RSLCT, bus.FLAGS, bus.BUSY);
    end
    RESET = 1'b1;
  endtask

  task automatic test_add();
    run_instr(32'hE0821003, 4'hF);
    checks++;
    if (bus.FLAGS !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b want 0000", bus.FLAGS); end
  endtask

  task automatic test_cond_flags();
    run_instr(32'hE0500000, 4'b0110);
    checks++;
    if (bus.FLAGS !== 4'b0110) begin errors++; $display("FAIL subs_flags: got %b want 0110", bus.FLAGS); end
    run_instr(32'h00844005, 4'h0);
    run_instr(32'h10844005, 4'h0);
  endtask

  task automatic test_cmp();
    run_instr(32'hE1510002, 4'b1000);
    checks++;
    if (bus.FLAGS !== 4'b1000) begin errors++; $display("FAIL cmp_flags: got %b want 1000", bus.FLAGS); end
  endtask

  task automatic test_illegal();
    logic [31:0] tbl [4] = '{32'hE2811001, 32'hF0821003, 32'hE0821103, 32'hE4821003};
    foreach (tbl[i]) run_instr(tbl[i], 4'b0101);
  endtask

  task automatic test_mov_pc();
    run_instr(32'hE1A0F003, 4'h0);
  endtask

  task automatic test_conditions();
    logic [3:0] pats [5] = '{4'b0000, 4'b0110, 4'b1001, 4'b1100, 4'b0011};
    foreach (pats[p]) begin
      run_instr(32'hE0944005, pats[p]);
      for (int c = 0; c < 15; c++) run_instr({c[3:0], 28'h0844005}, 4'hF);
    end
  endtask

  task automatic test_reset_mid_exec();
    int bad = 0;
    run_instr(32'hE0944005, 4'b1010);
    @(negedge Clk);
    bus.IR_IN = 32'hE0821003;
    bus.START = 1'b1;
    @(posedge Clk);
    #1 bus.START = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (bus.LOAD !== 1'b1) begin errors++; $display("FAIL mid_exec_load: got %b want 1", bus.LOAD); end
    #1 RESET = 1'b0;
    #1;
    checks++;
    if ({bus.RSLCT, bus.OP, bus.S, bus.ALU_OUT, bus.FLAGS, bus.LOAD, bus.LOADPC,
         bus.IR_CU, bus.BUSY, bus.DONE, bus.ILLEGAL} !== 37'h0) begin
      errors++; $display("FAIL async_reset: outputs nonzero, load=%b flags=%b busy=%b", bus.LOAD, bus.FLAGS, bus.BUSY);
    end
    model_flags = 4'h0;
    @(negedge Clk);
    RESET = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      if (bus.LOADPC || bus.BUSY || bus.DONE || bus.LOAD) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL after_reset_idle: %0d cycles with activity, want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] done_mask = '0;
    logic [4:0] op1 = '0, op2 = '0;
    logic       ld1 = 1'b0, ld2 = 1'b1, busy4 = 1'b1;
    @(negedge Clk);
    bus.IR_IN     = 32'hE0821003;
    bus.FLAGS_OUT = 4'b0101;
    bus.START     = 1'b1;
    @(posedge Clk);
    #1 bus.IR_IN = 32'hE1510002;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      if (bus.DONE) done_mask[n] = 1'b1;
      if (n == 1) begin op1 = bus.OP; ld1 = bus.LOAD; end
      if (n == 4) busy4 = bus.BUSY;
      if (n == 6) begin op2 = bus.OP; ld2 = bus.LOAD; end
      if (n == 9) bus.START = 1'b0;
    end
    model_flags = 4'b0101;
    checks += 5;
    if (done_mask !== 10'b01_0000_1000) begin errors++; $display("FAIL b2b_done_cycles: got %b want 0100001000", done_mask); end
    if (op1 !== 5'b00100 || ld1 !== 1'b1) begin errors++; $display("FAIL b2b_first: op=%b load=%b want 00100/1", op1, ld1); end
    if (op2 !== 5'b01010 || ld2 !== 1'b0) begin errors++; $display("FAIL b2b_second: op=%b load=%b want 01010/0", op2, ld2); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy4); end
    if (bus.FLAGS !== 4'b0101) begin errors++; $display("FAIL b2b_flags: got %b want 0101", bus.FLAGS); end
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.IR_IN     = 32'h0;
    bus.FLAGS_OUT = 4'h0;
    model_flags   = 4'h0;
    test_reset();
    test_add();
    test_cond_flags();
    test_cmp();
    test_illegal();
    test_mov_pc();
    test_conditions();
    test_reset_mid_exec();
    test_back_to_back();
    run_instr(32'hE0821003, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control FSM that executes one ARM data-processing instruction (register-operand form) on the RegisterFile + ARM_ALU datapath.
- Drives the register selects, ALU opcode/enables, register-write and PC-load strobes.
- Owns the architectural NZCV flag register and evaluates condition codes.
- Sits between the instruction source and the RF/ALU pair. An external +4 adder on PCout feeds Pcin.

Parameters:
- PC_REG, 15, register index that aliases the PC; Rd equal to it suppresses the PC-increment state.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request to execute IR_IN; sampled only in IDLE.
- IR_IN  input  32  instruction word.
- FLAGS_OUT  input  4  ALU result flags {N,Z,C,V}.
- RSLCT  output  20  [3:0] Rd write select, [7:4] Rn, [11:8] Rm, [15:12] Rs, [19:16] always 0.
- OP  output  5  ALU opcode {1'b0, IR[24:21]}.
- S  output  1  ALU flag-update enable.
- ALU_OUT  output  1  ALU output-drive enable (to shared in bus).
- FLAGS  output  4  architectural {N,Z,C,V} to ALU carry-in.
- LOAD  output  1  register-file write strobe.
- LOADPC  output  1  PC load strobe.
- IR_CU  output  1  1 = RSLCT sourced from this controller.
- BUSY  output  1  high from accepted START until DONE cycle inclusive.
- DONE  output  1  one-cycle completion pulse.
- ILLEGAL  output  1  valid with DONE: instruction not executed, unsupported encoding.

Behaviour:
- Reset (RESET=0, async):
  - FSM to IDLE; IR latch=0; FLAGS=0.
  - RSLCT=0, OP=0; S, ALU_OUT, LOAD, LOADPC, IR_CU, BUSY, DONE, ILLEGAL all 0.
  - Applies mid-instruction; no partial write or PC load may follow.
- States: IDLE -> DECODE -> EXEC -> PCINC -> DONE -> IDLE.
- IDLE:
  - BUSY=0, IR_CU=0.
  - START=1 at a rising edge: latch IR_IN, go to DECODE.
  - START outside IDLE is ignored; IR_IN is not re-sampled.
- DECODE (1 cycle):
  - IR_CU=1.
  - RSLCT[7:4]=IR[19:16], RSLCT[11:8]=IR[3:0], RSLCT[3:0]=IR[15:12], RSLCT[15:12]=IR[11:8].
  - Illegal when any of: IR[27:26]!=00, IR[25]=1, IR[11:4]!=0 (shifted operand), or cond IR[31:28]=1111. Illegal -> DONE with ILLEGAL=1. No LOAD, LOADPC or flag change.
  - Condition false -> PCINC (skip EXEC).
  - Condition true -> EXEC.
- Condition evaluation uses the FLAGS register (standard ARM semantics):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
- EXEC (1 cycle):
  - ALU_OUT=1, OP valid, selects held from DECODE.
  - S=IR[20].
  - LOAD=1 unless opcode in {1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN}.
  - At the ending edge: if IR[20]=1, FLAGS<=FLAGS_OUT. For TST/TEQ/CMP/CMN with IR[20]=0, flags are unchanged.
- PCINC (1 cycle):
  - LOADPC=1, except when EXEC wrote Rd==PC_REG (LOAD was 1); then LOADPC=0.
  - On a condition-failed path LOADPC=1 always.
- DONE (1 cycle): DONE=1, BUSY=1, ILLEGAL per decode; return to IDLE. Back-to-back: START may be accepted in the IDLE cycle right after DONE.
- Latency (START sampled at edge k):
  - Executed: DONE high in the cycle after edge k+3.
  - Illegal: after edge k+1.
  - Condition-failed: after edge k+2.
- Strobes (LOAD, LOADPC, S, ALU_OUT) are registered state decodes, glitch-free, each high exactly one cycle per instruction.

Test Plan:
- Reset then ADD R1,R2,R3 (IR=32'hE0821003), START 1 cycle -> DECODE RSLCT[7:4]=2,[11:8]=3,[3:0]=1; EXEC OP=5'b00100, LOAD=1, S=0; PCINC LOADPC=1; DONE at k+3; FLAGS stays 0000.
- SUBS R0,R0,R0 (32'hE0500000) -> S=1 in EXEC, FLAGS becomes 0110 (Z,C) from ALU; then ADDEQ R4,R4,R5 (32'h00844005) executes (LOAD=1); ADDNE (32'h10844005) skips EXEC (no LOAD), LOADPC=1, DONE at k+2.
- CMP R1,R2 (32'hE1510002) -> LOAD=0 in every cycle, FLAGS updated, LOADPC=1.
- Illegal words 32'hE2811001 (I=1) and 32'hF0821003 (cond 1111) -> DONE with ILLEGAL=1 at k+1; LOAD, LOADPC, FLAGS unchanged.
- MOV PC,R3 (32'hE1A0F003) -> LOAD=1 with RSLCT[3:0]=15, LOADPC=0 in PCINC.
- RESET low during EXEC -> all outputs 0 immediately (async), no LOADPC afterwards, FSM IDLE, FLAGS=0. START held high across DONE -> next instruction accepted only in IDLE, exactly one per DONE.
